// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared constants and helpers for the SECDED result display
package secded_pkg;

    // Decoder error-type encoding
    localparam logic [1:0] ET_NONE   = 2'b00;
    localparam logic [1:0] ET_SINGLE = 2'b01;
    localparam logic [1:0] ET_DOUBLE = 2'b10;

    // Status nibble shown for an uncorrectable codeword
    localparam logic [3:0] STATUS_DBL = 4'hE;

    // Active-low {a,b,c,d,e,f,g} patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Type 11 is not a legal decoder output; fold it onto the uncorrectable case
    function automatic logic [1:0] norm_err_type(input logic [1:0] t);
        return t[1] ? ET_DOUBLE : t;
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational hex nibble to active-low seven-segment pattern
//
// Ports:
//   hex  in  4  nibble to display (0-F)
//   seg  out 7  {a,b,c,d,e,f,g}, active-low
module seg7_hex_lut
    import secded_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/secded_result_display.sv
// rtl/secded_result_display.sv - captures SECDED decoder results and drives a 4-digit 7-seg display
//
// Parameters:
//   REFRESH_DIV  cycles each digit stays lit (>= 2)
//   CNT_W        width of each saturating error counter (<= 8)
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   res_valid        one-cycle strobe qualifying res_data/res_syndrome/res_error_type
//   res_data         corrected data nibble
//   res_syndrome     decoder syndrome {c2,c1,c0}
//   res_error_type   00 none, 01 corrected, 10/11 uncorrectable
//   cnt_sel          0 shows corrected count, 1 shows uncorrectable count
//   clr              synchronous clear of both counters and the sticky flag
//   dig              one-hot active-high digit enables, dig[3] leftmost
//   seg              active-low {a..g}
//   colon            active-low, lit while an uncorrectable result has been seen
//   led_err          last error type (11 folded to 10)
module secded_result_display
    import secded_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [3:0] res_data,
    input  logic [2:0] res_syndrome,
    input  logic [1:0] res_error_type,
    input  logic       cnt_sel,
    input  logic       clr,
    output logic [3:0] dig,
    output logic [6:0] seg,
    output logic       colon,
    output logic [1:0] led_err
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0]    ref_cnt;
    logic             ref_wrap;
    logic [1:0]       idx;
    logic [CNT_W-1:0] corr_cnt, dbl_cnt;
    logic [CNT_W-1:0] corr_base, dbl_base;
    logic [CNT_W-1:0] corr_next, dbl_next;
    logic             sticky_dbl;
    logic             have_result;
    logic [3:0]       data_q, status_q;
    logic [3:0]       status_next;
    logic [1:0]       et;
    logic             is_single, is_double;
    logic [7:0]       cnt8;
    logic [3:0]       nibble;
    logic [6:0]       lut_seg;
    logic [6:0]       seg_next;

    assign et        = norm_err_type(res_error_type);
    assign is_single = res_valid && (et == ET_SINGLE);
    assign is_double = res_valid && (et == ET_DOUBLE);
    assign ref_wrap  = (ref_cnt == RW'(REFRESH_DIV - 1));

    // clr acts before the same-cycle result, so a simultaneous result lands on zero
    always_comb begin
        corr_base = clr ? '0 : corr_cnt;
        dbl_base  = clr ? '0 : dbl_cnt;
        corr_next = corr_base;
        dbl_next  = dbl_base;
        if (is_single && (corr_base != '1)) corr_next = corr_base + CNT_W'(1);
        if (is_double && (dbl_base != '1))  dbl_next  = dbl_base + CNT_W'(1);
    end

    always_comb begin
        status_next = 4'h0;
        case (et)
            ET_NONE:   status_next = 4'h0;
            ET_SINGLE: status_next = {1'b0, res_syndrome};
            ET_DOUBLE: status_next = STATUS_DBL;
            default:   status_next = STATUS_DBL;
        endcase
    end

    // Nibble for the digit about to be registered; count is zero-extended to two hex digits
    always_comb begin
        cnt8   = 8'(cnt_sel ? dbl_cnt : corr_cnt);
        nibble = 4'h0;
        case (idx)
            2'd0: nibble = cnt8[3:0];
            2'd1: nibble = cnt8[7:4];
            2'd2: nibble = status_q;
            2'd3: nibble = data_q;
            default: nibble = 4'h0;
        endcase
    end

    seg7_hex_lut u_lut (
        .hex (nibble),
        .seg (lut_seg)
    );

    // Digits 3 and 2 carry no meaning until a result has been captured
    assign seg_next = (!have_result && idx[1]) ? SEG_DASH : lut_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            idx         <= 2'd0;
            corr_cnt    <= '0;
            dbl_cnt     <= '0;
            sticky_dbl  <= 1'b0;
            have_result <= 1'b0;
            data_q      <= 4'h0;
            status_q    <= 4'h0;
            led_err     <= ET_NONE;
            dig         <= 4'b0000;
            seg         <= SEG_BLANK;
            colon       <= 1'b1;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
            if (ref_wrap) idx <= idx + 2'd1;

            corr_cnt <= corr_next;
            dbl_cnt  <= dbl_next;

            if (clr)       sticky_dbl <= 1'b0;
            if (is_double) sticky_dbl <= 1'b1;

            if (res_valid) begin
                data_q      <= res_data;
                status_q    <= status_next;
                have_result <= 1'b1;
                led_err     <= et;
            end

            // dig and seg load from the same idx on the same edge, so they never disagree
            dig   <= 4'b0001 << idx;
            seg   <= seg_next;
            colon <= ~sticky_dbl;
        end
    end

endmodule

// File: tb/tb_secded_result_display.sv
// tb/tb_secded_result_display.sv - scoreboard bench for secded_result_display
module tb_secded_result_display;

    localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S2 = 7'h12, S3 = 7'h06;
    localparam logic [6:0] S4 = 7'h4C, S5 = 7'h24, S7 = 7'h0F, S9 = 7'h04;
    localparam logic [6:0] SA = 7'h08, SC = 7'h31, SE = 7'h30, SF = 7'h38;
    localparam logic [6:0] SDASH = 7'h7E, SBLANK = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic [3:0] res_data = 4'h0;
    logic [2:0] res_syndrome = 3'b000;
    logic [1:0] res_error_type = 2'b00;
    logic       cnt_sel = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       colon;
    logic [1:0] led_err;

    typedef struct packed {
        logic [3:0] d;
        logic [6:0] s;
    } exp_t;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;

    secded_result_display #(.REFRESH_DIV(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_syndrome   (res_syndrome),
        .res_error_type (res_error_type),
        .cnt_sel        (cnt_sel),
        .clr            (clr),
        .dig            (dig),
        .seg            (seg),
        .colon          (colon),
        .led_err        (led_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each newly lit digit is compared against the next queued expectation
    initial begin
        logic [3:0] prev;
        exp_t       e;
        prev = 4'b0000;
        forever begin
            @(negedge clk);
            if (rst_n && dig != prev && dig != 4'b0000 && q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("scan_dig(exp %b)", e.d), dig, e.d);
                check($sformatf("scan_seg(dig %b)", e.d), seg, e.s);
            end
            prev = dig;
        end
    end

    task automatic pulse(input logic [3:0] d, input logic [2:0] s, input logic [1:0] t);
        @(negedge clk);
        res_valid = 1'b1;
        res_data = d;
        res_syndrome = s;
        res_error_type = t;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    // Queue one full scan (dig0..dig3) and wait for the monitor to consume it
    task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0);
        int n;
        n = 0;
        @(negedge clk);
        while (dig != 4'b1000 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("scan_sync", dig, 4'b1000);
        @(posedge clk);
        q.push_back('{d: 4'b0001, s: s0});
        q.push_back('{d: 4'b0010, s: s1});
        q.push_back('{d: 4'b0100, s: s2});
        q.push_back('{d: 4'b1000, s: s3});
        n = 0;
        while (q.size() > 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("scan_drain", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] prevd;

        // Reset values
        #12;
        check("rst_dig", dig, 4'b0000);
        check("rst_seg", seg, SBLANK);
        check("rst_colon", colon, 1'b1);
        check("rst_led", led_err, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_dig", dig, 4'b0001);
        check("first_seg", seg, S0);

        // No result yet: dashes on the left
        scan(SDASH, SDASH, S0, S0);

        // Single corrected error
        pulse(4'hA, 3'b101, 2'b01);
        scan(SA, S5, S0, S1);
        check("single_led", led_err, 2'b01);
        check("single_colon", colon, 1'b1);

        // Uncorrectable error, show dbl count, then corr count unchanged
        pulse(4'h3, 3'b011, 2'b10);
        cnt_sel = 1'b1;
        scan(S3, SE, S0, S1);
        check("dbl_colon", colon, 1'b0);
        check("dbl_led", led_err, 2'b10);
        cnt_sel = 1'b0;
        scan(S3, SE, S0, S1);

        // Type 11 treated as uncorrectable
        pulse(4'hC, 3'b111, 2'b11);
        cnt_sel = 1'b1;
        scan(SC, SE, S0, S2);
        check("t11_led", led_err, 2'b10);

        // Saturation: 300 back-to-back corrected results on top of corr=1
        cnt_sel = 1'b0;
        @(negedge clk);
        res_valid = 1'b1;
        res_data = 4'h7;
        res_syndrome = 3'b001;
        res_error_type = 2'b01;
        repeat (300) @(negedge clk);
        res_valid = 1'b0;
        scan(S7, S1, SF, SF);
        pulse(4'h7, 3'b001, 2'b01);
        scan(S7, S1, SF, SF);

        // Bring dbl count from 2 to 7
        repeat (5) pulse(4'h9, 3'b000, 2'b10);
        cnt_sel = 1'b1;
        scan(S9, SE, S0, S7);

        // clr together with an uncorrectable result
        @(negedge clk);
        clr = 1'b1;
        res_valid = 1'b1;
        res_data = 4'h2;
        res_syndrome = 3'b000;
        res_error_type = 2'b10;
        @(negedge clk);
        clr = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        check("clrv_colon_early", colon, 1'b0);
        scan(S2, SE, S0, S1);
        check("clrv_colon", colon, 1'b0);
        cnt_sel = 1'b0;
        scan(S2, SE, S0, S0);

        // clr alone
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cnt_sel = 1'b1;
        scan(S2, SE, S0, S0);
        check("clr_colon", colon, 1'b1);

        // Scan timing: each digit held four cycles, in order, never dark
        n = 0;
        prevd = dig;
        @(negedge clk);
        while (!(dig == 4'b0001 && prevd == 4'b1000) && n < 64) begin
            prevd = dig;
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 32; i++) begin
            check($sformatf("hold_%0d", i), dig, 4'b0001 << ((i / 4) % 4));
            @(negedge clk);
        end

        // No-error result: status 0, no count change
        pulse(4'h4, 3'b000, 2'b00);
        scan(S4, S0, S0, S0);
        check("none_led", led_err, 2'b00);

        // Asynchronous reset mid-scan
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dig", dig, 4'b0000);
        check("async_rst_seg", seg, SBLANK);
        check("async_rst_colon", colon, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_first_dig", dig, 4'b0001);
        check("rerst_first_seg", seg, S0);
        scan(SDASH, SDASH, S0, S0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/secded_result_display.md
Name: secded_result_display

Overview:
- Downstream consumer of the SECDED (8,4) decoder stage on the extension board.
- Captures each decoder result on a valid strobe and keeps saturating counts of corrected and uncorrectable codewords.
- Drives the 4-digit multiplexed seven-segment display and the colon:
  - dig3: corrected data nibble.
  - dig2: status (syndrome or 'E').
  - dig1:dig0: selected error count, in hex.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit. Must be >= 2.
- CNT_W, 8, width of each error counter. Displayed as two hex digits, so CNT_W <= 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- res_valid  in  1  one-cycle strobe: a decoder result is present
- res_data  in  4  corrected data nibble from the decoder
- res_syndrome  in  3  decoder syndrome {c2,c1,c0}
- res_error_type  in  2  00 no error, 01 single corrected, 10 uncorrectable; 11 is treated as 10
- cnt_sel  in  1  0: show corrected count, 1: show uncorrectable count
- clr  in  1  synchronous clear of counters and sticky flag
- dig  out  4  digit enables, one-hot, active-high; dig[3] is leftmost
- seg  out  7  {a,b,c,d,e,f,g}, active-low
- colon  out  1  active-low; lit while the sticky uncorrectable flag is set
- led_err  out  2  registered copy of the last error type, for board LEDs

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state is reset by rst_n and updated on the clk rising edge.
- Reset values:
  - dig=4'b0000, seg=7'b1111111, colon=1, led_err=2'b00.
  - Counters=0, digit index=0, refresh counter=0, have_result=0, sticky_dbl=0.
  - Captured data=0, captured status=0.
- Capture, on a cycle with res_valid=1:
  - Latch res_data.
  - Status nibble = {1'b0,res_syndrome} when type 01; 4'hE when type 10/11; 4'h0 when type 00.
  - Set have_result=1 and led_err=type, with 11 mapped to 10.
  - All take effect the next cycle.
- Counters:
  - corr_cnt increments on a valid result of type 01.
  - dbl_cnt increments on a valid result of type 10/11.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - sticky_dbl is set on a valid result of type 10/11.
- clr:
  - Forces both counters and sticky_dbl to 0.
  - If res_valid is also high in the same cycle, the clear applies first and the new result is then counted (the counter ends at 1), and sticky_dbl is set again for type 10/11.
  - clr does not affect captured data, status or have_result.
- Refresh:
  - ref_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
- Digit index to digit and displayed value:
  - idx0 → dig[0], low nibble of the selected count.
  - idx1 → dig[1], high nibble of the selected count (zero-extended when CNT_W<8).
  - idx2 → dig[2], status nibble.
  - idx3 → dig[3], data nibble.
- Output registers:
  - dig and seg are registered and change together one cycle after the index changes.
  - No digit is ever driven with another digit's segments.
- Before the first result (have_result=0), digits 3 and 2 show a dash (seg=7'b1111110).
- cnt_sel is sampled combinationally into the segment register path, so a change is visible on the next lit count digit.
- colon = ~sticky_dbl, registered.
- A res_valid pulse arriving mid-scan updates content without disturbing scan timing.

Decomposition:
- Shared package secded_pkg holds:
  - Error-type constants: ET_NONE=2'b00, ET_SINGLE=2'b01, ET_DOUBLE=2'b10.
  - Status code STATUS_DBL=4'hE.
  - Segment constants: SEG_BLANK=7'h7F, SEG_DASH=7'b1111110.
- One sub-module, seg7_hex_lut: a combinational 4-bit hex to active-low {a..g} lookup covering 0-F. It is instantiated once on the selected nibble.

Test Plan (REFRESH_DIV=4, CNT_W=8):
- Reset: hold rst_n low mid-scan → dig=0000, seg=7F and colon=1 immediately, independent of clk. After release, first dig=0001 one cycle later, with seg showing '0'.
- Single error: res_valid with data=4'hA, syndrome=3'b101, type=01 → one full scan shows dig3 'A', dig2 '5', dig1:dig0 "01"; led_err=01; colon=1.
- Uncorrectable error: res_valid with type=10, then cnt_sel=1 → dig2 'E', dig1:dig0 "01", colon=0, corr_cnt unchanged.
- Saturation: 300 valid type-01 pulses → corr_cnt=FF and display "FF"; 301st pulse leaves FF.
- Clear with simultaneous result: clr=1 and res_valid=1 with type=10 in the same cycle, with dbl_cnt=7 beforehand → dbl_cnt=1, colon stays 0. Then clr alone → dbl_cnt=0, colon=1, dig3 still shows the last data.
- Scan timing: with no inputs for 32 cycles → each dig one-hot value is held exactly 4 cycles, in order 0001,0010,0100,1000, and dig is never 0000 after the first cycle.
